// File: rtl/wts_mix_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wts_mix_pkg
// Brief   : Shared types, constants and output-fit helper for the volume mixer.
// Revision: 1.0 - initial release
// ============================================================================
package wts_mix_pkg;

    localparam int VOL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } mix_state_t;

    // Maps a sign-extended accumulator onto out_w bits: clamp or wrap.
    function automatic logic signed [31:0] sat_fit(input logic signed [31:0] acc,
                                                   input int out_w);
`ifdef WTS_MIX_SATURATE_EN
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
`else
        return (acc <<< (32 - out_w)) >>> (32 - out_w);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/wts_ch_scale.sv
`default_nettype none
// ============================================================================
// Module  : wts_ch_scale
// Brief   : Per-channel scaler: registered sample*envelope, then volume scale.
// Revision: 1.0 - initial release
// ============================================================================
module wts_ch_scale
    import wts_mix_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ENV_W  = 8,
    parameter int ACC_W  = 11
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     capture,
    input  logic                     first,
    input  logic                     last,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic        [ENV_W-1:0]  env_in,
    input  logic        [VOL_W-1:0]  vol_in,
    output logic                     c_valid,
    output logic                     c_first,
    output logic                     c_last,
    output logic signed [ACC_W-1:0]  c
);

    localparam int PW = DATA_W + ENV_W + 1;
    localparam int SW = PW + VOL_W + 1;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] p_q;
    logic [VOL_W-1:0]     vol_q;
    logic                 en_q;
    logic signed [SW-1:0] scaled;

    assign prod = PW'(sample_in) * PW'($signed({1'b0, env_in}));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            c_valid <= 1'b0;
            c_first <= 1'b0;
            c_last  <= 1'b0;
            p_q     <= '0;
            vol_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            c_valid <= capture;
            if (capture) begin
                c_first <= first;
                c_last  <= last;
                p_q     <= prod;
                vol_q   <= vol_in;
                en_q    <= enable;
            end
        end
    end

    // Arithmetic shift floors toward -inf, so -128*255*15 lands on -120.
    assign scaled = (SW'(p_q) * SW'($signed({1'b0, vol_q}))) >>> (ENV_W + VOL_W);
    assign c      = en_q ? ACC_W'(scaled) : '0;

endmodule
`default_nettype wire

// File: rtl/wts_volume_mixer.sv
`default_nettype none
// ============================================================================
// Module  : wts_volume_mixer
// Brief   : Time-multiplexed NUM_CH-channel volume scaler and mixer.
//           Define WTS_MIX_SATURATE_EN to clamp (instead of wrap) narrow outputs.
// Revision: 1.0 - initial release
// ============================================================================
module wts_volume_mixer
    import wts_mix_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 8,
    parameter int ENV_W  = 8,
    parameter int OUT_W  = 11
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       start,
    input  logic [NUM_CH-1:0]          ch_enable,
    output logic [$clog2(NUM_CH)-1:0]  ch_sel,
    input  logic signed [DATA_W-1:0]   sample_in,
    input  logic [ENV_W-1:0]           env_in,
    input  logic [VOL_W-1:0]           vol_in,
    output logic                       busy,
    output logic signed [OUT_W-1:0]    mix_out,
    output logic                       mix_valid
);

    localparam int CW    = $clog2(NUM_CH);
    localparam int ACC_W = DATA_W + $clog2(NUM_CH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    mix_state_t state;
    mix_state_t next_state;
    logic [CW-1:0] ch_sel_next;
    logic          capture;

    logic                    c_valid;
    logic                    c_first;
    logic                    c_last;
    logic signed [ACC_W-1:0] c;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state  <= IDLE;
            ch_sel <= '0;
        end else begin
            state  <= next_state;
            ch_sel <= ch_sel_next;
        end
    end

    always_comb begin
        next_state  = state;
        ch_sel_next = ch_sel;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state  = FETCH;
                    ch_sel_next = '0;
                end
            end
            FETCH: begin
                capture = 1'b1;
                if (ch_sel == LAST_CH) begin
                    next_state  = DRAIN;
                    ch_sel_next = '0;
                end else begin
                    ch_sel_next = ch_sel + CW'(1);
                end
            end
            DRAIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    wts_ch_scale #(
        .DATA_W (DATA_W),
        .ENV_W  (ENV_W),
        .ACC_W  (ACC_W)
    ) u_scale (
        .clk       (clk),
        .nreset    (nreset),
        .capture   (capture),
        .first     (ch_sel == '0),
        .last      (ch_sel == LAST_CH),
        .enable    (ch_enable[ch_sel]),
        .sample_in (sample_in),
        .env_in    (env_in),
        .vol_in    (vol_in),
        .c_valid   (c_valid),
        .c_first   (c_first),
        .c_last    (c_last),
        .c         (c)
    );

    assign acc_sum = acc + c;

    // The last channel's contribution bypasses acc straight into the output fit.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (c_valid) begin
                if (c_last) begin
                    mix_out   <= OUT_W'(sat_fit(32'(acc_sum), OUT_W));
                    mix_valid <= 1'b1;
                end else begin
                    acc <= c_first ? c : acc_sum;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wts_volume_mixer.sv
`default_nettype none
// ============================================================================
// Module  : tb_wts_volume_mixer
// Brief   : Self-checking bench: wide (OUT_W=11) and narrow (OUT_W=9) mixers.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wts_volume_mixer;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic start = 1'b0;
    logic [4:0] en = '0;

    logic signed [7:0] smp  [8];
    logic        [7:0] envv [8];
    logic        [3:0] volv [8];

    logic [2:0]        ch_sel_w, ch_sel_n;
    logic signed [7:0] sample_w, sample_n;
    logic [7:0]        env_w, env_n;
    logic [3:0]        vol_w, vol_n;
    logic              busy_w, busy_n;
    logic signed [10:0] mix_w;
    logic signed [8:0]  mix_n;
    logic              mv_w, mv_n;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign sample_w = smp[ch_sel_w];
    assign env_w    = envv[ch_sel_w];
    assign vol_w    = volv[ch_sel_w];
    assign sample_n = smp[ch_sel_n];
    assign env_n    = envv[ch_sel_n];
    assign vol_n    = volv[ch_sel_n];

    wts_volume_mixer #(.NUM_CH(5), .DATA_W(8), .ENV_W(8), .OUT_W(11)) dut (
        .clk(clk), .nreset(nreset), .start(start), .ch_enable(en), .ch_sel(ch_sel_w),
        .sample_in(sample_w), .env_in(env_w), .vol_in(vol_w), .busy(busy_w),
        .mix_out(mix_w), .mix_valid(mv_w)
    );

    wts_volume_mixer #(.NUM_CH(5), .DATA_W(8), .ENV_W(8), .OUT_W(9)) dut_n (
        .clk(clk), .nreset(nreset), .start(start), .ch_enable(en), .ch_sel(ch_sel_n),
        .sample_in(sample_n), .env_in(env_n), .vol_in(vol_n), .busy(busy_n),
        .mix_out(mix_n), .mix_valid(mv_n)
    );

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Sum of floor(s*e*v / 4096) over enabled channels.
    function automatic int ref_mix();
        int sum = 0;
        for (int k = 0; k < 5; k++) begin
            if (en[k]) begin
                int n = int'(smp[k]) * int'(envv[k]) * int'(volv[k]);
                int q = n / 4096;
                if (n < 0 && q * 4096 != n) q--;
                sum += q;
            end
        end
        return sum;
    endfunction

    function automatic int fit9(input int x);
`ifdef WTS_MIX_SATURATE_EN
        if (x > 255) return 255;
        if (x < -256) return -256;
        return x;
`else
        int m = ((x % 512) + 512) % 512;
        return (m >= 256) ? m - 512 : m;
`endif
    endfunction

    task automatic set_all(input int s, input int e, input int v, input logic [4:0] m);
        for (int k = 0; k < 8; k++) begin
            smp[k]  = 8'(s);
            envv[k] = 8'(e);
            volv[k] = 4'(v);
        end
        en = m;
    endtask

    // Pulses start for one edge (E0) and waits for the wide mixer's mix_valid.
    task automatic run_frame(output int lat, output int got, output int got9, output int b0);
        lat  = -1;
        got  = 0;
        got9 = 9999;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        b0 = int'(busy_w) + int'(ch_sel_w);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (mv_w) begin
                lat = k;
                got = int'(mix_w);
                if (mv_n) got9 = int'(mix_n);
                break;
            end
        end
    endtask

    typedef struct {
        int         s;
        int         e;
        int         v;
        logic [4:0] m;
        int         exp11;
        int         exp9;
    } vec_t;

    vec_t vecs [5];
    int lat, got, got9, b0, held, pulses;
    int pulse_at [$];

    initial begin
`ifdef WTS_MIX_SATURATE_EN
        vecs[0] = '{127, 255, 15, 5'b11111,  590,  255};
        vecs[1] = '{-128, 255, 15, 5'b11111, -600, -256};
`else
        vecs[0] = '{127, 255, 15, 5'b11111,  590,   78};
        vecs[1] = '{-128, 255, 15, 5'b11111, -600,  -88};
`endif
        vecs[2] = '{127, 255, 0,  5'b11111,    0,    0};
        vecs[3] = '{127, 255, 15, 5'b00001,  118,  118};
        vecs[4] = '{127, 255, 15, 5'b00000,    0,    0};

        set_all(0, 0, 0, 5'b0);
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mix_out", int'(mix_w), 0);
        check("reset_mix_valid", int'(mv_w), 0);
        check("reset_busy", int'(busy_w), 0);
        check("reset_ch_sel", int'(ch_sel_w), 0);
        nreset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            set_all(vecs[i].s, vecs[i].e, vecs[i].v, vecs[i].m);
            run_frame(lat, got, got9, b0);
            check($sformatf("vec%0d_busy_e0", i), b0, 1);
            check($sformatf("vec%0d_latency", i), lat, 6);
            check($sformatf("vec%0d_mix11", i), got, vecs[i].exp11);
            check($sformatf("vec%0d_mix9", i), got9, vecs[i].exp9);
            check($sformatf("vec%0d_busy_done", i), int'(busy_w), 0);
            held = int'(mix_w);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse_1cyc", i), int'(mv_w), 0);
            check($sformatf("vec%0d_mix_held", i), int'(mix_w), held);
        end

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 8; k++) begin
                smp[k]  = 8'($urandom);
                envv[k] = 8'($urandom);
                volv[k] = 4'($urandom);
            end
            en = 5'($urandom);
            if (i < 4) en = 5'b11111;
            run_frame(lat, got, got9, b0);
            check($sformatf("rnd%0d_latency", i), lat, 6);
            check($sformatf("rnd%0d_mix11", i), got, ref_mix());
            check($sformatf("rnd%0d_mix9", i), got9, fit9(ref_mix()));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // start held high: frames back to back every NUM_CH+2 cycles
        set_all(127, 255, 15, 5'b11111);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (mv_w) pulse_at.push_back(c);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        check("held_pulse_count", pulse_at.size(), 5);
        if (pulse_at.size() > 0) check("held_first_pulse", pulse_at[0], 6);
        for (int i = 1; i < pulse_at.size(); i++)
            check($sformatf("held_period%0d", i), pulse_at[i] - pulse_at[i-1], 7);

        // reset asserted at E3 discards the in-flight frame
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        check("midrst_busy", int'(busy_w), 0);
        check("midrst_ch_sel", int'(ch_sel_w), 0);
        check("midrst_mix_out", int'(mix_w), 0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (mv_w || mv_n) pulses++;
        end
        check("midrst_no_valid", pulses, 0);
        run_frame(lat, got, got9, b0);
        check("post_rst_latency", lat, 6);
        check("post_rst_mix11", got, 590);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
